// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: rising-edge capture, mask, fixed priority,
// two-cycle entry (push return address, then load vector), no nesting until iret.
module irq_ctrl #(
   parameter int              NIRQ     = 4,
   parameter int              PC_W     = 10,
   parameter logic [PC_W-1:0] VEC_BASE = 10'h3E0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NIRQ-1:0] irq,
   input  logic            mask_we,
   input  logic [NIRQ-1:0] mask_in,
   input  logic            gie_set,
   input  logic            gie_clr,
   input  logic            iret,
   input  logic [PC_W-1:0] pc_next,
   input  logic            stack_full,
   output logic            stall,
   output logic            push_ret,
   output logic [PC_W-1:0] ret_addr,
   output logic            take_vec,
   output logic [PC_W-1:0] vec_pc,
   output logic [NIRQ-1:0] irq_ack,
   output logic            in_isr,
   output logic [NIRQ-1:0] pending
);

   localparam int SEL_W = (NIRQ > 1) ? $clog2(NIRQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_PUSH, S_VECTOR, S_ISR} state_t;

   state_t           r_state;
   logic [NIRQ-1:0]  r_irq_d;
   logic [NIRQ-1:0]  r_mask;
   logic             r_gie;
   logic [SEL_W-1:0] r_sel;

   logic [NIRQ-1:0]  w_rise;
   logic [NIRQ-1:0]  w_elig;
   logic [NIRQ-1:0]  w_sel_oh;
   logic [NIRQ-1:0]  w_clr;
   logic [SEL_W-1:0] w_win;
   logic             w_enter;

   assign w_rise   = irq & ~r_irq_d;
   assign w_elig   = pending & r_mask;
   assign w_sel_oh = NIRQ'(1) << r_sel;
   // A fresh edge on the serviced line in the VECTOR cycle must survive the clear.
   assign w_clr    = (r_state == S_VECTOR) ? w_sel_oh : '0;
   assign w_enter  = r_gie & (|w_elig) & ~stack_full;

   // Lowest set index wins: scan downward so the last hit is the lowest.
   always_comb begin
      w_win = '0;
      for (int i = NIRQ - 1; i >= 0; i--)
         if (w_elig[i]) w_win = SEL_W'(i);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_irq_d  <= '0;
         r_mask   <= '0;
         r_gie    <= 1'b0;
         r_sel    <= '0;
         pending  <= '0;
         ret_addr <= '0;
         vec_pc   <= VEC_BASE;
         stall    <= 1'b0;
         push_ret <= 1'b0;
         take_vec <= 1'b0;
         irq_ack  <= '0;
         in_isr   <= 1'b0;
      end else begin
         r_irq_d  <= irq;
         pending  <= (pending & ~w_clr) | w_rise;
         stall    <= 1'b0;
         push_ret <= 1'b0;
         take_vec <= 1'b0;
         irq_ack  <= '0;
         if (mask_we) r_mask <= mask_in;
         if (gie_clr)      r_gie <= 1'b0;
         else if (gie_set) r_gie <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_enter) begin
                  r_sel    <= w_win;
                  ret_addr <= pc_next;
                  vec_pc   <= VEC_BASE + PC_W'({w_win, 2'b00});
                  stall    <= 1'b1;
                  push_ret <= 1'b1;
                  r_state  <= S_PUSH;
               end
            end
            S_PUSH: begin
               take_vec <= 1'b1;
               irq_ack  <= w_sel_oh;
               r_state  <= S_VECTOR;
            end
            S_VECTOR: begin
               r_gie   <= 1'b0;
               in_isr  <= 1'b1;
               r_state <= S_ISR;
            end
            S_ISR: begin
               if (iret) begin
                  r_gie   <= 1'b1;
                  in_isr  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: entry timing, priority, masking, stack-full
// deferral, re-capture during VECTOR, and reset in mid-sequence.
module tb_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq;
   logic       mask_we;
   logic [3:0] mask_in;
   logic       gie_set, gie_clr, iret;
   logic [9:0] pc_next;
   logic       stack_full;
   logic       stall, push_ret, take_vec, in_isr;
   logic [9:0] ret_addr, vec_pc;
   logic [3:0] irq_ack, pending;

   int errors = 0;
   int checks = 0;

   irq_ctrl #(.NIRQ(4), .PC_W(10), .VEC_BASE(10'h3E0)) dut (
      .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
      .gie_set(gie_set), .gie_clr(gie_clr), .iret(iret), .pc_next(pc_next),
      .stack_full(stack_full), .stall(stall), .push_ret(push_ret),
      .ret_addr(ret_addr), .take_vec(take_vec), .vec_pc(vec_pc),
      .irq_ack(irq_ack), .in_isr(in_isr), .pending(pending)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_iret();
      iret = 1'b1;
      tick();
      iret = 1'b0;
   endtask

   task automatic set_mask(input logic [3:0] m);
      mask_we = 1'b1; mask_in = m;
      tick();
      mask_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; irq = '0; mask_we = 0; mask_in = '0; gie_set = 0; gie_clr = 0;
      iret = 0; pc_next = 10'h123; stack_full = 0;
      tick(); tick();
      reset = 1'b0;
      tick();
      checks++; if (stall !== 1'b0)      begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
      checks++; if (push_ret !== 1'b0)   begin errors++; $display("FAIL reset_push got %b exp 0", push_ret); end
      checks++; if (ret_addr !== 10'h0)  begin errors++; $display("FAIL reset_ret got %h exp 000", ret_addr); end
      checks++; if (vec_pc !== 10'h3E0)  begin errors++; $display("FAIL reset_vec got %h exp 3e0", vec_pc); end
      checks++; if (irq_ack !== 4'h0 || take_vec !== 1'b0 || in_isr !== 1'b0)
         begin errors++; $display("FAIL reset_strobes got ack=%b tv=%b isr=%b exp 0", irq_ack, take_vec, in_isr); end
      checks++; if (pending !== 4'h0)    begin errors++; $display("FAIL reset_pending got %b exp 0000", pending); end
   endtask

   task automatic test_basic();
      gie_set = 1'b1;
      set_mask(4'b1111);
      gie_set = 1'b0;
      irq = 4'b0100;
      tick(); irq = '0;
      checks++; if (pending !== 4'b0100 || push_ret !== 1'b0)
         begin errors++; $display("FAIL basic_pending got %b push=%b exp 0100 push=0", pending, push_ret); end
      tick();
      checks++; if (push_ret !== 1'b1 || stall !== 1'b1 || ret_addr !== 10'h123)
         begin errors++; $display("FAIL basic_push got push=%b stall=%b ret=%h exp 1 1 123", push_ret, stall, ret_addr); end
      tick();
      checks++; if (take_vec !== 1'b1 || vec_pc !== 10'h3E8 || irq_ack !== 4'b0100 || push_ret !== 1'b0)
         begin errors++; $display("FAIL basic_vector got tv=%b vec=%h ack=%b push=%b exp 1 3e8 0100 0", take_vec, vec_pc, irq_ack, push_ret); end
      tick();
      checks++; if (in_isr !== 1'b1 || pending !== 4'b0000 || irq_ack !== 4'b0000 || take_vec !== 1'b0)
         begin errors++; $display("FAIL basic_isr got isr=%b pend=%b ack=%b tv=%b exp 1 0000 0000 0", in_isr, pending, irq_ack, take_vec); end
      do_iret();
      checks++; if (in_isr !== 1'b0) begin errors++; $display("FAIL basic_iret got isr=%b exp 0", in_isr); end
   endtask

   task automatic test_priority();
      irq = 4'b1010;
      tick(); irq = '0;
      checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL prio_pending got %b exp 1010", pending); end
      tick(); tick();
      checks++; if (vec_pc !== 10'h3E4 || irq_ack !== 4'b0010)
         begin errors++; $display("FAIL prio_first got vec=%h ack=%b exp 3e4 0010", vec_pc, irq_ack); end
      tick();
      checks++; if (pending !== 4'b1000 || in_isr !== 1'b1)
         begin errors++; $display("FAIL prio_mid got pend=%b isr=%b exp 1000 1", pending, in_isr); end
      tick();
      checks++; if (push_ret !== 1'b0) begin errors++; $display("FAIL prio_nonest got push=%b exp 0", push_ret); end
      do_iret();
      tick();
      checks++; if (push_ret !== 1'b1) begin errors++; $display("FAIL prio_second_push got %b exp 1", push_ret); end
      tick();
      checks++; if (vec_pc !== 10'h3EC || irq_ack !== 4'b1000)
         begin errors++; $display("FAIL prio_second got vec=%h ack=%b exp 3ec 1000", vec_pc, irq_ack); end
      tick();
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL prio_drained got %b exp 0000", pending); end
      do_iret();
   endtask

   task automatic test_mask();
      set_mask(4'b0000);
      irq = 4'b0001;
      tick(); irq = '0;
      checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL mask_pending got %b exp 0001", pending); end
      tick(); tick();
      checks++; if (push_ret !== 1'b0 || in_isr !== 1'b0)
         begin errors++; $display("FAIL mask_blocked got push=%b isr=%b exp 0 0", push_ret, in_isr); end
      set_mask(4'b0001);
      checks++; if (push_ret !== 1'b0) begin errors++; $display("FAIL mask_write_cycle got %b exp 0", push_ret); end
      tick();
      checks++; if (push_ret !== 1'b1) begin errors++; $display("FAIL mask_entry got %b exp 1", push_ret); end
      tick();
      checks++; if (vec_pc !== 10'h3E0 || irq_ack !== 4'b0001)
         begin errors++; $display("FAIL mask_vector got vec=%h ack=%b exp 3e0 0001", vec_pc, irq_ack); end
      tick();
      do_iret();
      set_mask(4'b1111);
   endtask

   task automatic test_stack_full();
      stack_full = 1'b1;
      pc_next = 10'h2A5;
      irq = 4'b0100;
      tick(); irq = '0;
      tick(); tick();
      checks++; if (push_ret !== 1'b0 || pending !== 4'b0100)
         begin errors++; $display("FAIL sf_defer got push=%b pend=%b exp 0 0100", push_ret, pending); end
      stack_full = 1'b0;
      tick();
      checks++; if (push_ret !== 1'b1 || ret_addr !== 10'h2A5)
         begin errors++; $display("FAIL sf_release got push=%b ret=%h exp 1 2a5", push_ret, ret_addr); end
      tick();
      checks++; if (vec_pc !== 10'h3E8) begin errors++; $display("FAIL sf_vector got %h exp 3e8", vec_pc); end
      tick();
      do_iret();
   endtask

   task automatic test_back_to_back();
      irq = 4'b0100;
      tick(); irq = '0;
      tick();
      tick();
      irq = 4'b0100;
      checks++; if (take_vec !== 1'b1) begin errors++; $display("FAIL b2b_vector got %b exp 1", take_vec); end
      tick(); irq = '0;
      checks++; if (pending !== 4'b0100 || in_isr !== 1'b1)
         begin errors++; $display("FAIL b2b_set_wins got pend=%b isr=%b exp 0100 1", pending, in_isr); end
      do_iret();
      tick();
      checks++; if (push_ret !== 1'b1) begin errors++; $display("FAIL b2b_reentry got %b exp 1", push_ret); end
      tick();
      checks++; if (vec_pc !== 10'h3E8 || irq_ack !== 4'b0100)
         begin errors++; $display("FAIL b2b_vector2 got vec=%h ack=%b exp 3e8 0100", vec_pc, irq_ack); end
      tick();
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL b2b_cleared got %b exp 0000", pending); end
      do_iret();
   endtask

   task automatic test_reset_mid();
      irq = 4'b0001;
      tick(); irq = '0;
      tick();
      checks++; if (push_ret !== 1'b1) begin errors++; $display("FAIL rst_pre_push got %b exp 1", push_ret); end
      reset = 1'b1;
      #1;
      checks++; if (push_ret !== 1'b0 || stall !== 1'b0 || in_isr !== 1'b0 || pending !== 4'b0000)
         begin errors++; $display("FAIL rst_async got push=%b stall=%b isr=%b pend=%b exp 0 0 0 0000", push_ret, stall, in_isr, pending); end
      tick();
      checks++; if (take_vec !== 1'b0 || irq_ack !== 4'b0000 || vec_pc !== 10'h3E0)
         begin errors++; $display("FAIL rst_no_ack got tv=%b ack=%b vec=%h exp 0 0000 3e0", take_vec, irq_ack, vec_pc); end
      reset = 1'b0;
      gie_set = 1'b1;
      set_mask(4'b1111);
      gie_set = 1'b0;
      tick(); tick(); tick();
      checks++; if (push_ret !== 1'b0 || pending !== 4'b0000)
         begin errors++; $display("FAIL rst_no_edge got push=%b pend=%b exp 0 0000", push_ret, pending); end
      irq = 4'b0010;
      tick(); irq = '0;
      tick();
      checks++; if (push_ret !== 1'b1) begin errors++; $display("FAIL rst_new_edge got %b exp 1", push_ret); end
      tick();
      checks++; if (vec_pc !== 10'h3E4) begin errors++; $display("FAIL rst_new_vec got %h exp 3e4", vec_pc); end
      tick();
      do_iret();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_mask();
      test_stack_full();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Vectored interrupt controller for the 16-bit single-cycle CPU. Sits beside the control unit and PC logic.
- Captures edge-triggered requests and masks them, then picks one by fixed priority.
- Sequences entry in two cycles: stall and push of the return address onto the hardware stack, then a PC load with the vector.
- Blocks nesting until the ISR signals return.

Parameters:
NIRQ, 4, number of interrupt lines (2..8)
PC_W, 10, program-counter / return-address width
VEC_BASE, 10'h3E0, vector base; vector(i) = VEC_BASE + {i, 2'b00}

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
irq  in  NIRQ  external request lines, rising-edge sensitive, synchronous to clk
mask_we  in  1  write strobe for enable mask (from decode)
mask_in  in  NIRQ  new mask value; bit=1 enables line
gie_set  in  1  global interrupt enable set (decode)
gie_clr  in  1  global interrupt enable clear (decode)
iret  in  1  return-from-interrupt strobe (decode of pop-to-PC)
pc_next  in  PC_W  address of the next sequential instruction
stack_full  in  1  hardware stack full flag
stall  out  1  freezes PC and suppresses we3/wez/we4/we5 this cycle
push_ret  out  1  stack push strobe with ret_addr as data
ret_addr  out  PC_W  return address to push
take_vec  out  1  PC mux select: load vec_pc
vec_pc  out  PC_W  vector address
irq_ack  out  NIRQ  one-hot, one-cycle acknowledge of the serviced line
in_isr  out  1  handler active
pending  out  NIRQ  pending register (readable through input port)

Behaviour:
- Reset, asynchronous:
  - State IDLE.
  - pending=0, mask=0, gie=0, irq_d=0, sel=0, ret_addr=0.
  - All strobes 0, in_isr=0, vec_pc=VEC_BASE.
- Edge detect:
  - irq_d <= irq each cycle.
  - pending[i] set when irq[i] & ~irq_d[i].
  - pending[i] cleared only in the VECTOR cycle for the serviced i.
  - Set and clear of the same bit in the same cycle: set wins, bit stays 1.
- mask and gie:
  - mask_we: mask <= mask_in at the clock edge.
  - gie_set and gie_clr both 1: gie_clr wins.
  - Masked lines still become pending but are not serviced.
- Eligibility: eligible = pending & mask. Winner = lowest set index (bit 0 highest priority).
- FSM states: IDLE, PUSH, VECTOR, ISR.
- IDLE:
  - If gie & |eligible & ~stack_full: capture sel <= winner index and ret_addr <= pc_next, then go to PUSH.
  - Otherwise stay in IDLE.
  - If stack_full, the entry is deferred; pending is kept.
- PUSH (1 cycle):
  - stall=1, push_ret=1, ret_addr is held.
  - Next state VECTOR.
- VECTOR (1 cycle):
  - take_vec=1, vec_pc = VEC_BASE + {sel, 2'b00}, truncated to PC_W.
  - irq_ack[sel]=1, pending[sel] cleared.
  - gie forced to 0.
  - Next state ISR.
- ISR:
  - in_isr=1, no new entry.
  - iret=1 → IDLE, and gie <= 1 (restored) on the same edge.
- Latency: irq edge at cycle N → pending at N+1 → PUSH at N+2 → VECTOR at N+3 → first ISR fetch at N+4.
- iret in IDLE/PUSH/VECTOR is ignored.
- gie_set/gie_clr are honoured in ISR, but entry is still blocked until iret.
- mask change in IDLE takes effect for the next cycle's eligibility evaluation.
- sel is latched in IDLE; a higher-priority edge arriving during PUSH does not change the vector. It is serviced after iret.
- Reset mid-sequence (PUSH/VECTOR/ISR):
  - Immediate return to reset values.
  - No further push or acknowledge.
- All outputs are registered state decodes. No combinational path from irq to any output.

Test Plan:
- Reset, gie_set, mask=4'b1111, pulse irq[2] at cycle 10 → pending=4'b0100 at 11; push_ret with ret_addr=pc_next at 12; take_vec, vec_pc=10'h3E8, irq_ack=4'b0100 at 13; in_isr from 14.
- irq[3] and irq[1] rise in the same cycle → vec_pc=10'h3E4 first; after iret, the next entry gives vec_pc=10'h3EC; pending goes 1010→1000→0000.
- mask=4'b0000, irq[0] edge → pending[0]=1, no push. Then mask_we with 4'b0001 → entry starts 1 cycle later, vec_pc=10'h3E0.
- stack_full=1 with eligible irq → stays IDLE, no push_ret. Drop stack_full → PUSH next cycle.
- New irq[2] edge in the VECTOR cycle that clears pending[2] → pending[2] remains 1 and is re-serviced after iret.
- Assert reset during PUSH → same cycle: push_ret=0, in_isr=0, pending=0. After release, irq edges are required again for entry.
